// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//   Shared definitions for the simple 16-bit processor control path:
//   opcode encodings, the timestep state type, and the bit positions of the
//   III / XXX / YYY fields inside the 9-bit instruction register.
// ---------------------------------------------------------------------------
package proc_pkg;

  // Instruction opcodes (III field); 100..111 are reserved
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Instruction field layout: III XXX YYY
  localparam int FIELD_W   = 3;
  localparam int IR_OP_MSB = 8;
  localparam int IR_X_MSB  = 5;
  localparam int IR_Y_MSB  = 2;

  // Timesteps, binary encoded so all four codes are legal states
  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

endpackage

// File: rtl/dec3to8.sv
// ---------------------------------------------------------------------------
// dec3to8
//   Decodes a 3-bit register index into a one-hot [0:7] vector, where bit 0
//   (the MSB) corresponds to index 0. With i_en low the output is all zeros.
//
//   Ports:
//     i_idx  [2:0]  register index
//     i_en          decode enable
//     o_hot  [0:7]  one-hot result
// ---------------------------------------------------------------------------
module dec3to8 (
  input  logic [2:0] i_idx,
  input  logic       i_en,
  output logic [0:7] o_hot
);

  always_comb begin
    o_hot = '0;
    if (i_en) begin
      o_hot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Sequencing FSM for the simple 16-bit processor. Latches a 9-bit
//   instruction from the top of DIN in T0 and steps through T1..T3 to run
//   mv, mvi, add and sub by driving the bus-mux selects and datapath enables.
//   Only the state and IR are registered; every other output is a
//   combinational decode of (state, IR).
//
//   Ports:
//     Clock         rising-edge system clock
//     Resetn        asynchronous active-low reset
//     Run           start request, only looked at in T0
//     DIN           instruction (T0) / immediate for mvi (T1)
//     Rout  [0:7]   one-hot register-to-bus select, Rout[0] = R0
//     Gout          G to bus
//     DINout        DIN to bus
//     Rin   [0:7]   one-hot register load enable, Rin[0] = R0
//     Ain           load A from bus
//     Gin           load G from ALU
//     AddSub        ALU control, 1 = subtract
//     Done          last cycle of the current instruction
//     IR            instruction register (debug view)
// ---------------------------------------------------------------------------
module control_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [0:7]        Rout,
  output logic              Gout,
  output logic              DINout,
  output logic [0:7]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done,
  output logic [IR_W-1:0]   IR
);

  state_t              r_state;
  state_t              w_nextState;
  logic [IR_W-1:0]     r_ir;

  logic [FIELD_W-1:0]  w_op;
  logic [FIELD_W-1:0]  w_x;
  logic [FIELD_W-1:0]  w_y;

  logic                w_routEn;
  logic [FIELD_W-1:0]  w_routSel;
  logic                w_rinEn;

  // The low DIN bits carry immediates for the datapath, not instruction bits
  logic                w_unusedDin;
  assign w_unusedDin = ^DIN[DATA_W-IR_W-1:0];

  assign w_op = r_ir[IR_OP_MSB -: FIELD_W];
  assign w_x  = r_ir[IR_X_MSB  -: FIELD_W];
  assign w_y  = r_ir[IR_Y_MSB  -: FIELD_W];
  assign IR   = r_ir;

  // State and instruction registers; IR only loads when a new instruction
  // is accepted in T0, so it stays stable for the rest of the instruction.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == T0) && Run) begin
        r_ir <= DIN[DATA_W-1 -: IR_W];
      end
    end
  end

  // Next-state and output decode. The register-to-bus select reads X in T1
  // (first add/sub operand into A) and Y everywhere else.
  always_comb begin
    w_nextState = r_state;
    w_routEn    = 1'b0;
    w_routSel   = w_y;
    w_rinEn     = 1'b0;
    Gout        = 1'b0;
    DINout      = 1'b0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    AddSub      = 1'b0;
    Done        = 1'b0;

    unique case (r_state)
      T0: begin
        w_nextState = Run ? T1 : T0;
      end

      T1: begin
        unique case (w_op)
          OP_MV: begin
            w_routEn    = 1'b1;
            w_routSel   = w_y;
            w_rinEn     = 1'b1;
            Done        = 1'b1;
            w_nextState = T0;
          end
          OP_MVI: begin
            DINout      = 1'b1;
            w_rinEn     = 1'b1;
            Done        = 1'b1;
            w_nextState = T0;
          end
          OP_ADD, OP_SUB: begin
            w_routEn    = 1'b1;
            w_routSel   = w_x;
            Ain         = 1'b1;
            w_nextState = T2;
          end
          default: begin
            // Reserved opcodes retire immediately without touching the datapath
            Done        = 1'b1;
            w_nextState = T0;
          end
        endcase
      end

      T2: begin
        w_routEn    = 1'b1;
        w_routSel   = w_y;
        Gin         = 1'b1;
        AddSub      = (w_op == OP_SUB);
        w_nextState = T3;
      end

      T3: begin
        Gout        = 1'b1;
        w_rinEn     = 1'b1;
        Done        = 1'b1;
        w_nextState = T0;
      end

      default: begin
        w_nextState = T0;
      end
    endcase
  end

  dec3to8 u_routDec (
    .i_idx (w_routSel),
    .i_en  (w_routEn),
    .o_hot (Rout)
  );

  dec3to8 u_rinDec (
    .i_idx (w_x),
    .i_en  (w_rinEn),
    .o_hot (Rin)
  );

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Directed bench for control_unit: walks mvi, mv, add, sub and a reserved
//   opcode through their timesteps, checks async reset mid-instruction, and
//   keeps a per-cycle watch on the bus-driver and register-load one-hot rules.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic [0:7]  Rout;
  logic        Gout;
  logic        DINout;
  logic [0:7]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic [8:0]  IR;

  int nChecks = 0;
  int nPass   = 0;

  control_unit #(.DATA_W(16), .IR_W(9)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .Rout   (Rout),
    .Gout   (Gout),
    .DINout (DINout),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .IR     (IR)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive inputs just after a rising edge, then let outputs settle
  task automatic applyStimulus(input logic run, input logic [15:0] din);
    Run = run;
    DIN = din;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Compare every decoded output as one vector:
  // {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done}
  task automatic checkOutput(input string tag,
                             input logic [7:0] expRout,
                             input logic expGout, input logic expDinout,
                             input logic [7:0] expRin,
                             input logic expAin, input logic expGin,
                             input logic expAddSub, input logic expDone);
    logic [21:0] obs;
    logic [21:0] exp;
    obs = {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done};
    exp = {expRout, expGout, expDinout, expRin, expAin, expGin, expAddSub, expDone};
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: outputs {Rout,Gout,DINout,Rin,Ain,Gin,AddSub,Done} observed %b expected %b",
                tag, obs, exp);
  endtask

  task automatic checkIr(input string tag, input logic [8:0] expIr);
    nChecks++;
    assert (IR === expIr) nPass++;
    else $error("[TB] FAIL %s: IR observed %h expected %h", tag, IR, expIr);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Every cycle out of reset: at most one bus driver and at most one Rin bit
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      nChecks++;
      assert (($countones({Rout, Gout, DINout}) <= 1) === 1'b1) nPass++;
      else $error("[TB] FAIL busOneHot: drivers observed %b expected at most one set",
                  {Rout, Gout, DINout});
      nChecks++;
      assert (($countones(Rin) <= 1) === 1'b1) nPass++;
      else $error("[TB] FAIL rinOneHot: Rin observed %b expected at most one set", Rin);
    end
  end

  initial begin
    // Power-up reset, checked before any clock edge has occurred
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = 16'h0000;
    #2;
    checkIdle("resetInit");
    checkIr("resetInitIr", 9'h000);
    tick();
    Resetn = 1'b1;
    tick();
    checkIdle("idleT0");

    // mvi R0, #00A5
    applyStimulus(1'b1, 16'h2000);
    tick();
    applyStimulus(1'b0, 16'h00A5);
    checkOutput("mviT1", 8'b00000000, 1'b0, 1'b1, 8'b10000000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkIr("mviIr", 9'h040);
    tick();
    checkIdle("mviBackToT0");

    // mv R7, R5
    applyStimulus(1'b1, 16'h1E80);
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("mvT1", 8'b00000100, 1'b0, 1'b0, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b1);
    checkIr("mvIr", 9'h03D);
    tick();
    checkIdle("mvBackToT0");

    // add R1, R2
    applyStimulus(1'b1, 16'h4500);
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("addT1", 8'b01000000, 1'b0, 1'b0, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("addT2", 8'b00100000, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("addT3", 8'b00000000, 1'b1, 1'b0, 8'b01000000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkIdle("addBackToT0");

    // sub R3, R4 with a stray Run pulse (and a new DIN) during T2
    applyStimulus(1'b1, 16'h6E00);
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("subT1", 8'b00010000, 1'b0, 1'b0, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h2000);
    checkOutput("subT2", 8'b00001000, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("subT3", 8'b00000000, 1'b1, 1'b0, 8'b00010000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkIr("subIrHeld", 9'h0DC);
    tick();
    checkIdle("subBackToT0");

    // Reserved opcode, then back-to-back add with Run held high
    applyStimulus(1'b1, 16'hA000);
    tick();
    applyStimulus(1'b1, 16'h4500);
    checkOutput("rsvdT1", 8'b00000000, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkIr("rsvdIr", 9'h140);
    tick();
    checkIdle("b2bT0");
    tick();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("b2bAddT1", 8'b01000000, 1'b0, 1'b0, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkIr("b2bAddIr", 9'h08A);
    tick();
    checkOutput("b2bAddT2", 8'b00100000, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("b2bAddT3", 8'b00000000, 1'b1, 1'b0, 8'b01000000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkIdle("b2bBackToT0");

    // Async reset in the middle of T2 of an add
    applyStimulus(1'b1, 16'h4500);
    tick();
    applyStimulus(1'b0, 16'h0000);
    tick();
    checkOutput("preResetT2", 8'b00100000, 1'b0, 1'b0, 8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    Resetn = 1'b0;
    #1;
    checkIdle("midResetOutputs");
    checkIr("midResetIr", 9'h000);
    tick();
    Resetn = 1'b1;
    tick();
    checkIdle("postResetT0");
    tick();
    checkIdle("postResetStillT0");

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Sequencing FSM for the simple 16-bit processor. It sits directly upstream of the bus multiplexer and drives that mux's select inputs (Rout, Gout, DINout). It also drives the register-file, A and G load enables and the ALU add/sub control. It latches a 9-bit instruction from DIN and steps through timesteps T0–T3 to execute mv, mvi, add and sub.

Parameters:
DATA_W, 16, width of DIN and of the datapath bus.
IR_W, 9, instruction width. Fixed format III XXX YYY, taken from DIN[DATA_W-1 -: IR_W].

Ports:
Clock  input  1  single system clock, rising edge.
Resetn  input  1  asynchronous, active-low reset.
Run  input  1  start request; sampled only in T0.
DIN  input  DATA_W  instruction word in T0; immediate data for mvi in T1.
Rout  output  [0:7]  one-hot register-to-bus select; Rout[0] (MSB) selects R0, Rout[7] selects R7.
Gout  output  1  G register to bus.
DINout  output  1  DIN to bus.
Rin  output  [0:7]  one-hot register load enable; Rin[0] loads R0.
Ain  output  1  load A from bus.
Gin  output  1  load G from ALU result.
AddSub  output  1  0 = add, 1 = subtract.
Done  output  1  final cycle of the current instruction.
IR  output  IR_W  current instruction register, for debug.

Behaviour:
- Reset: async on Resetn=0. State goes to T0, IR=0, all outputs 0 immediately with no clock edge needed. Reset mid-instruction abandons it; no enables are asserted afterwards.
- Structure: state and IR are registers. All other outputs are combinational decodes of (state, IR), so enables take effect at the end of the cycle in which they are asserted.
- Opcodes III = IR[8:6], X = IR[5:3], Y = IR[2:0]: 000 mv, 001 mvi, 010 add, 011 sub, 100–111 reserved.
- T0: all outputs 0. If Run=1 at the rising edge, IR <= DIN[15:7] and go to T1; otherwise stay in T0. Run is ignored in T1–T3.
- T1:
  - mv: Rout[Y]=1, Rin[X]=1, Done=1; go to T0.
  - mvi: DINout=1, Rin[X]=1, Done=1; go to T0. The immediate must be presented on DIN during T1.
  - add/sub: Rout[X]=1, Ain=1; go to T2.
  - reserved: Done=1 only, no enables; go to T0.
- T2 (add/sub): Rout[Y]=1, Gin=1, AddSub=(III==011); go to T3.
- T3 (add/sub): Gout=1, Rin[X]=1, Done=1; go to T0.
- Latency from the Run edge to Done high: 1 cycle for mv/mvi, 3 cycles for add/sub. Done is high for exactly one cycle per instruction.
- Bus-driver invariant: at most one of {Rout bits, Gout, DINout} is 1 in any cycle. A ≤1 Rin bit is 1 in any cycle.
- X==Y is legal. For example, mv R3,R3 asserts Rout[3] and Rin[3] in the same cycle.
- Back-to-back: Run held high re-fetches DIN in the T0 that follows Done. There is no idle cycle beyond T0.
- State encoding: 2-bit binary (T0=00, T1=01, T2=10, T3=11). Unreachable states cannot occur.

Decomposition:
- Shared package (proc_pkg):
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - state typedef/localparams T0..T3;
  - IR field index constants.
- One natural sub-module: dec3to8. It decodes a 3-bit register index to a one-hot [0:7] vector, with bit 0 corresponding to index 0. It has an enable input (en=0 gives all zeros). Two instances are used, for Rout (X/Y select muxed by state) and for Rin.

Test Plan:
1. Resetn=0 mid-T2 of an add. Required: state goes to T0 immediately, and Rout, Rin, Ain, Gin, Gout, DINout, AddSub, Done and IR are all 0 before the next edge.
2. Run=1, DIN=16'h2000 (mvi R0), then DIN=16'h00A5 in T1. Required in T1: DINout=1, Rin=8'b10000000, Done=1, all Rout bits 0. Next cycle is T0.
3. DIN=16'h1E80 (mv R7,R5). Required in T1: Rout=8'b00000100, Rin=8'b00000001, Done=1.
4. DIN=16'h4500 (add R1,R2). Required:
   - T1: Rout=8'b01000000, Ain=1.
   - T2: Rout=8'b00100000, Gin=1, AddSub=0.
   - T3: Gout=1, Rin=8'b01000000, Done=1.
5. DIN=16'h6E00 (sub R3,R4). Required: T2 has Rout=8'b00001000, Gin=1, AddSub=1; T3 has Rin=8'b00010000, Done=1. Separately, a Run pulse during T2 must be ignored.
6. DIN=16'hA000 (reserved opcode). Required in T1: Done=1 and no other output asserted. Then, with Run held at 1, the add at 16'h4500 runs in the immediately following T0/T1, with a bus-driver one-hot assertion checked on every cycle.
